// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-state encoding and datapath widths
package cpu_pkg;

  localparam int PC_W  = 8;
  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] HALT_OPCODE_DEFAULT = 4'hF;

  typedef enum logic [1:0] {
    FS_ISSUE   = 2'd0,
    FS_CAPTURE = 2'd1,
    FS_HOLD    = 2'd2,
    FS_HALT    = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program counter with load, increment and natural wrap
module pc_reg
  import cpu_pkg::*;
#(
  parameter int              WIDTH     = PC_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  output logic [WIDTH-1:0] pc
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;

  // Load wins over increment; the add wraps at the register width.
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_val;
    end else if (inc) begin
      pc_d = pc_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_VAL;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch FSM and instruction register feeding decode
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0]  RESET_PC    = 8'h00,
  parameter logic [OPC_W-1:0] HALT_OPCODE = HALT_OPCODE_DEFAULT,
  parameter int               OPC_MSB     = 31
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic [31:0]       DataBus_in,
  input  logic              mem_busy,
  input  logic              branch_valid,
  input  logic [PC_W-1:0]   branch_target,
  input  logic              ir_ready,
  output logic [PC_W-1:0]   PC_Instruction_Acces,
  output logic [31:0]       IR,
  output logic [OPC_W-1:0]  OP_code,
  output logic              ir_valid,
  output logic              halted
);

  fetch_state_e state_q, state_d;
  logic [31:0]  ir_q, ir_d;
  logic         ir_valid_q, ir_valid_d;
  logic         halted_q, halted_d;
  logic         pc_load;
  logic         pc_inc;
  logic [PC_W-1:0] pc;

  pc_reg #(
    .WIDTH     (PC_W),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk      (CLK),
    .rst_n    (RST_n),
    .load     (pc_load),
    .load_val (branch_target),
    .inc      (pc_inc),
    .pc       (pc)
  );

  assign OP_code = ir_q[OPC_MSB -: OPC_W];

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    halted_d   = halted_q;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;

    // A redirect flushes whatever is in flight or held, including a pending HALT.
    if (branch_valid && (state_q != FS_HALT)) begin
      pc_load    = 1'b1;
      ir_valid_d = 1'b0;
      state_d    = FS_ISSUE;
    end else begin
      case (state_q)
        FS_ISSUE: begin
          if (!mem_busy) begin
            state_d = FS_CAPTURE;
          end
        end
        FS_CAPTURE: begin
          // Data access stole the bus: the word on DataBus_in is not ours.
          if (mem_busy) begin
            state_d = FS_ISSUE;
          end else begin
            ir_d       = DataBus_in;
            ir_valid_d = 1'b1;
            pc_inc     = 1'b1;
            state_d    = FS_HOLD;
          end
        end
        FS_HOLD: begin
          if (ir_ready) begin
            ir_valid_d = 1'b0;
            if (OP_code == HALT_OPCODE) begin
              halted_d = 1'b1;
              state_d  = FS_HALT;
            end else begin
              state_d = FS_ISSUE;
            end
          end
        end
        FS_HALT: begin
          ir_valid_d = 1'b0;
        end
        default: begin
          state_d    = FS_ISSUE;
          ir_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= FS_ISSUE;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
    end
  end

  assign PC_Instruction_Acces = pc;
  assign IR                   = ir_q;
  assign ir_valid             = ir_valid_q;
  assign halted               = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        CLK;
  logic        RST_n;
  logic [31:0] DataBus_in;
  logic        mem_busy;
  logic        branch_valid;
  logic [7:0]  branch_target;
  logic        ir_ready;
  logic [7:0]  PC_Instruction_Acces;
  logic [31:0] IR;
  logic [3:0]  OP_code;
  logic        ir_valid;
  logic        halted;

  logic [31:0] mem [256];
  logic [31:0] exp_q [$];
  int          n_cmp;
  int          n_fail;

  instr_fetch_unit dut (
    .CLK                  (CLK),
    .RST_n                (RST_n),
    .DataBus_in           (DataBus_in),
    .mem_busy             (mem_busy),
    .branch_valid         (branch_valid),
    .branch_target        (branch_target),
    .ir_ready             (ir_ready),
    .PC_Instruction_Acces (PC_Instruction_Acces),
    .IR                   (IR),
    .OP_code              (OP_code),
    .ir_valid             (ir_valid),
    .halted               (halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synchronous memory: word for the presented address appears one cycle later.
  always @(posedge CLK) DataBus_in <= mem[PC_Instruction_Acces];

  task automatic test_reset();
    RST_n = 1'b0; mem_busy = 1'b0; branch_valid = 1'b0; branch_target = 8'h00; ir_ready = 1'b0;
    repeat (2) @(negedge CLK);
    n_cmp++; if (PC_Instruction_Acces !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h want 00", PC_Instruction_Acces); end
    n_cmp++; if (IR !== 32'h0) begin n_fail++; $display("FAIL reset_ir: got %h want 00000000", IR); end
    n_cmp++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ir_valid); end
    n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
    n_cmp++; if (OP_code !== 4'h0) begin n_fail++; $display("FAIL reset_opcode: got %h want 0", OP_code); end
  endtask

  task automatic test_basic_fetch();
    logic [31:0] e;
    exp_q.push_back(mem[0]);
    ir_ready = 1'b1;
    RST_n = 1'b1;
    n_cmp++; if (PC_Instruction_Acces !== 8'h00 || ir_valid !== 1'b0) begin n_fail++; $display("FAIL basic_issue: got pc %h valid %b want pc 00 valid 0", PC_Instruction_Acces, ir_valid); end
    repeat (2) @(negedge CLK);
    e = exp_q.pop_front();
    n_cmp++; if (ir_valid !== 1'b1 || IR !== e) begin n_fail++; $display("FAIL basic_capture: got valid %b ir %h want valid 1 ir %h", ir_valid, IR, e); end
    n_cmp++; if (PC_Instruction_Acces !== 8'h01) begin n_fail++; $display("FAIL basic_pc_inc: got %h want 01", PC_Instruction_Acces); end
    @(negedge CLK);
    n_cmp++; if (ir_valid !== 1'b0 || PC_Instruction_Acces !== 8'h01) begin n_fail++; $display("FAIL basic_accept: got valid %b pc %h want valid 0 pc 01", ir_valid, PC_Instruction_Acces); end
    ir_ready = 1'b0;
  endtask

  task automatic test_mem_busy();
    logic [31:0] e, ir_prev;
    int k;
    branch_valid = 1'b1; branch_target = 8'h05; exp_q.push_back(mem[8'h05]);
    @(negedge CLK);
    branch_valid = 1'b0;
    n_cmp++; if (PC_Instruction_Acces !== 8'h05) begin n_fail++; $display("FAIL busy_branch_pc: got %h want 05", PC_Instruction_Acces); end
    ir_prev = IR;
    @(negedge CLK);
    mem_busy = 1'b1;
    @(negedge CLK);
    n_cmp++; if (IR !== ir_prev || ir_valid !== 1'b0 || PC_Instruction_Acces !== 8'h05) begin n_fail++; $display("FAIL busy_void_capture: got ir %h valid %b pc %h want ir %h valid 0 pc 05", IR, ir_valid, PC_Instruction_Acces, ir_prev); end
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_cmp++; if (PC_Instruction_Acces !== 8'h05 || ir_valid !== 1'b0) begin n_fail++; $display("FAIL busy_stall_%0d: got pc %h valid %b want pc 05 valid 0", i, PC_Instruction_Acces, ir_valid); end
    end
    mem_busy = 1'b0;
    k = 0; while (!ir_valid && k < 20) begin @(negedge CLK); k++; end
    e = exp_q.pop_front();
    n_cmp++; if (ir_valid !== 1'b1 || IR !== e || PC_Instruction_Acces !== 8'h06) begin n_fail++; $display("FAIL busy_refetch: got valid %b ir %h pc %h want valid 1 ir %h pc 06", ir_valid, IR, PC_Instruction_Acces, e); end
    ir_ready = 1'b1; @(negedge CLK); ir_ready = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    int k;
    branch_valid = 1'b1; branch_target = 8'hFF; exp_q.push_back(mem[8'hFF]);
    @(negedge CLK);
    branch_valid = 1'b0;
    k = 0; while (!ir_valid && k < 20) begin @(negedge CLK); k++; end
    e = exp_q.pop_front();
    n_cmp++; if (ir_valid !== 1'b1 || IR !== e) begin n_fail++; $display("FAIL wrap_capture: got valid %b ir %h want valid 1 ir %h", ir_valid, IR, e); end
    n_cmp++; if (PC_Instruction_Acces !== 8'h00) begin n_fail++; $display("FAIL wrap_pc: got %h want 00", PC_Instruction_Acces); end
    ir_ready = 1'b1; @(negedge CLK); ir_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    int got, last;
    got = 0; last = 0;
    ir_ready = 1'b1;
    branch_valid = 1'b1; branch_target = 8'h50;
    for (int i = 0; i < 4; i++) exp_q.push_back(mem[8'h50 + i]);
    @(negedge CLK);
    branch_valid = 1'b0;
    for (int c = 0; c < 15 && got < 4; c++) begin
      if (ir_valid) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_DEAD;
        n_cmp++; if (IR !== e) begin n_fail++; $display("FAIL b2b_ir_%0d: got %h want %h", got, IR, e); end
        n_cmp++; if (got > 0 && c - last != 3) begin n_fail++; $display("FAIL b2b_gap_%0d: got %0d cycles want 3", got, c - last); end
        last = c;
        got++;
      end
      @(negedge CLK);
    end
    n_cmp++; if (got != 4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", got); end
    ir_ready = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_branch_capture();
    logic [31:0] e, ir_prev;
    int k;
    branch_valid = 1'b1; branch_target = 8'h10;
    @(negedge CLK);
    branch_valid = 1'b0;
    ir_prev = IR;
    @(negedge CLK);
    branch_valid = 1'b1; branch_target = 8'h40; exp_q.push_back(mem[8'h40]);
    @(negedge CLK);
    branch_valid = 1'b0;
    n_cmp++; if (ir_valid !== 1'b0 || IR !== ir_prev || PC_Instruction_Acces !== 8'h40) begin n_fail++; $display("FAIL brcap_flush: got valid %b ir %h pc %h want valid 0 ir %h pc 40", ir_valid, IR, PC_Instruction_Acces, ir_prev); end
    k = 0; while (!ir_valid && k < 20) begin @(negedge CLK); k++; end
    e = exp_q.pop_front();
    n_cmp++; if (ir_valid !== 1'b1 || IR !== e || PC_Instruction_Acces !== 8'h41) begin n_fail++; $display("FAIL brcap_refetch: got valid %b ir %h pc %h want valid 1 ir %h pc 41", ir_valid, IR, PC_Instruction_Acces, e); end
    ir_ready = 1'b1; @(negedge CLK); ir_ready = 1'b0;
  endtask

  task automatic test_branch_hold();
    logic [31:0] e;
    int k;
    branch_valid = 1'b1; branch_target = 8'h20;
    @(negedge CLK);
    branch_valid = 1'b0;
    k = 0; while (!ir_valid && k < 20) begin @(negedge CLK); k++; end
    n_cmp++; if (ir_valid !== 1'b1 || IR !== 32'hF000_0001) begin n_fail++; $display("FAIL brhold_pending: got valid %b ir %h want valid 1 ir f0000001", ir_valid, IR); end
    ir_ready = 1'b1; branch_valid = 1'b1; branch_target = 8'h40; exp_q.push_back(mem[8'h40]);
    @(negedge CLK);
    ir_ready = 1'b0; branch_valid = 1'b0;
    n_cmp++; if (ir_valid !== 1'b0 || halted !== 1'b0 || PC_Instruction_Acces !== 8'h40) begin n_fail++; $display("FAIL brhold_drop: got valid %b halted %b pc %h want valid 0 halted 0 pc 40", ir_valid, halted, PC_Instruction_Acces); end
    k = 0; while (!ir_valid && k < 20) begin @(negedge CLK); k++; end
    e = exp_q.pop_front();
    n_cmp++; if (ir_valid !== 1'b1 || IR !== e || PC_Instruction_Acces !== 8'h41 || halted !== 1'b0) begin n_fail++; $display("FAIL brhold_refetch: got valid %b ir %h pc %h halted %b want valid 1 ir %h pc 41 halted 0", ir_valid, IR, PC_Instruction_Acces, halted, e); end
    ir_ready = 1'b1; @(negedge CLK); ir_ready = 1'b0;
  endtask

  task automatic test_halt();
    logic [31:0] e;
    int k;
    branch_valid = 1'b1; branch_target = 8'h80; exp_q.push_back(mem[8'h80]);
    @(negedge CLK);
    branch_valid = 1'b0;
    k = 0; while (!ir_valid && k < 20) begin @(negedge CLK); k++; end
    e = exp_q.pop_front();
    n_cmp++; if (IR !== e || OP_code !== 4'hF) begin n_fail++; $display("FAIL halt_capture: got ir %h op %h want ir %h op f", IR, OP_code, e); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (ir_valid !== 1'b1 || halted !== 1'b0) begin n_fail++; $display("FAIL halt_hold_%0d: got valid %b halted %b want valid 1 halted 0", i, ir_valid, halted); end
      @(negedge CLK);
    end
    ir_ready = 1'b1;
    @(negedge CLK);
    ir_ready = 1'b0;
    n_cmp++; if (halted !== 1'b1 || ir_valid !== 1'b0 || PC_Instruction_Acces !== 8'h81) begin n_fail++; $display("FAIL halt_enter: got halted %b valid %b pc %h want halted 1 valid 0 pc 81", halted, ir_valid, PC_Instruction_Acces); end
    branch_valid = 1'b1; branch_target = 8'h10;
    @(negedge CLK);
    branch_valid = 1'b0;
    repeat (3) @(negedge CLK);
    n_cmp++; if (halted !== 1'b1 || ir_valid !== 1'b0 || PC_Instruction_Acces !== 8'h81) begin n_fail++; $display("FAIL halt_frozen: got halted %b valid %b pc %h want halted 1 valid 0 pc 81", halted, ir_valid, PC_Instruction_Acces); end
  endtask

  task automatic test_async_reset();
    logic [31:0] e;
    int k;
    #2 RST_n = 1'b0;
    #1;
    n_cmp++; if (halted !== 1'b0 || PC_Instruction_Acces !== 8'h00) begin n_fail++; $display("FAIL arst_from_halt: got halted %b pc %h want halted 0 pc 00", halted, PC_Instruction_Acces); end
    @(negedge CLK);
    RST_n = 1'b1;
    branch_valid = 1'b1; branch_target = 8'h30;
    @(negedge CLK);
    branch_valid = 1'b0;
    @(negedge CLK);
    #2 RST_n = 1'b0;
    #1;
    n_cmp++; if (PC_Instruction_Acces !== 8'h00 || ir_valid !== 1'b0 || IR !== 32'h0 || halted !== 1'b0) begin n_fail++; $display("FAIL arst_mid_capture: got pc %h valid %b ir %h halted %b want pc 00 valid 0 ir 0 halted 0", PC_Instruction_Acces, ir_valid, IR, halted); end
    @(negedge CLK);
    RST_n = 1'b1;
    exp_q.push_back(mem[8'h00]);
    k = 0; while (!ir_valid && k < 20) begin @(negedge CLK); k++; end
    e = exp_q.pop_front();
    n_cmp++; if (ir_valid !== 1'b1 || IR !== e || PC_Instruction_Acces !== 8'h01) begin n_fail++; $display("FAIL arst_resume: got valid %b ir %h pc %h want valid 1 ir %h pc 01", ir_valid, IR, PC_Instruction_Acces, e); end
    ir_ready = 1'b1; @(negedge CLK); ir_ready = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    for (int i = 0; i < 256; i++) mem[i] = {8'h30, i[7:0], 16'hBEEF};
    mem[8'h00] = 32'h1234_5678;
    mem[8'hFF] = 32'hA5A5_0FF0;
    mem[8'h20] = 32'hF000_0001;
    mem[8'h80] = 32'hF000_0000;
    test_reset();
    test_basic_fetch();
    test_mem_busy();
    test_wrap();
    test_back_to_back();
    test_branch_capture();
    test_branch_hold();
    test_halt();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
